fifo_sel_dispatch: RTL

- Consumer end of the FIFO-select interface: takes the 8-bit select code and drains one complete packet from the chosen input FIFO.
- Select code format: bit7=1 means valid, bits[6:0] carry the port index; 8'd0 means no selection.
- Drains by issuing read strobes and forwards words on a valid/ready stream, with SOP/EOP marking.
- Pulses pkt_done when the packet ends so the selector upstream can release or re-arbitrate.

---
 rtl/fifo_sel_dispatch_if.sv | 29 ++
 rtl/fifo_sel_dispatch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sel_dispatch_if.sv
// Bundle between the FIFO-select dispatcher and its surroundings: input FIFO read side,
// the select code, the forwarded valid/ready word stream and packet status.
interface fifo_sel_dispatch_if #(
  parameter int PORT_NUM = 2,
  parameter int DATA_W   = 32
);
  logic [7:0]                 fifo_sel_code;
  logic [PORT_NUM-1:0]        fifo_empty;
  logic [PORT_NUM*DATA_W-1:0] fifo_rd_data;
  logic [PORT_NUM-1:0]        fifo_rd_en;
  logic [DATA_W-1:0]          out_data;
  logic                       out_valid;
  logic                       out_sop;
  logic                       out_eop;
  logic                       out_ready;
  logic                       busy;
  logic [6:0]                 cur_port;
  logic                       pkt_done;

  modport master (
    input  fifo_sel_code, fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_data, out_valid, out_sop, out_eop, busy, cur_port, pkt_done
  );

  modport slave (
    output fifo_sel_code, fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_sop, out_eop, busy, cur_port, pkt_done
  );
endinterface

// File: rtl/fifo_sel_dispatch.sv
// Locks the FIFO named by the select code and drains one whole packet onto a valid/ready stream.
// FIFO reads return one cycle later; reads are credit-limited by a 2-entry buffer so backpressure never drops words.
module fifo_sel_dispatch #(
  parameter int PORT_NUM = 2,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8
) (
  input logic                 glb_clk,
  input logic                 glb_areset_n,
  fifo_sel_dispatch_if.master bus
);
  typedef enum logic [2:0] {IDLE, HDR, BODY, DRAIN, DONE} state_t;
  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] dat;
  } beat_t;

  state_t            state;
  logic [6:0]        lock_port;
  logic              busy_q;
  logic              done_q;
  logic              hdr_issued;
  logic              inflight;
  logic [LEN_W-1:0]  issued_cnt;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  ret_cnt;
  logic [1:0]        occ;
  beat_t             buf0;
  beat_t             buf1;

  logic              sel_empty;
  logic [DATA_W-1:0] sel_data;
  logic [LEN_W-1:0]  len_now;
  logic [LEN_W-1:0]  rem_now;
  logic [LEN_W-1:0]  rem_eff;
  logic              hdr_ret;
  logic              pop;
  logic [2:0]        level;
  logic              want_hdr;
  logic              want_body;
  logic              rd;
  logic              last_issue;
  beat_t             new_beat;

  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (lock_port == 7'(i)) begin
        sel_empty = bus.fifo_empty[i];
        sel_data  = bus.fifo_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The header's length is usable in the cycle it returns, so the first body read
  // can go out back-to-back with the header instead of leaving a bubble.
  assign len_now   = sel_data[LEN_W-1:0];
  assign rem_now   = (len_now == '0) ? '0 : len_now - LEN_W'(1);
  assign hdr_ret   = inflight && (ret_cnt == '0);
  assign rem_eff   = hdr_ret ? rem_now : remaining;

  // Credit counts the slot freed by this cycle's pop, keeping 1 word/cycle under out_ready.
  assign pop       = (occ != 2'd0) && bus.out_ready;
  assign level     = 3'(occ) + 3'(inflight) - 3'(pop);
  assign want_hdr  = (state == HDR) && !hdr_issued;
  assign want_body = ((state == BODY) || ((state == HDR) && hdr_ret)) && (issued_cnt < rem_eff);
  assign rd        = (want_hdr || want_body) && (level < 3'd2) && !sel_empty;
  assign last_issue = want_body && rd && (issued_cnt == rem_eff - LEN_W'(1));

  assign new_beat  = '{sop: (ret_cnt == '0), eop: (ret_cnt == rem_eff), dat: sel_data};

  always_comb begin
    bus.fifo_rd_en = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      bus.fifo_rd_en[i] = rd && (lock_port == 7'(i));
    end
  end

  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = buf0.dat;
  assign bus.out_sop   = buf0.sop;
  assign bus.out_eop   = buf0.eop;
  assign bus.busy      = busy_q;
  assign bus.cur_port  = lock_port;
  assign bus.pkt_done  = done_q;

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      state      <= IDLE;
      lock_port  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hdr_issued <= 1'b0;
      inflight   <= 1'b0;
      issued_cnt <= '0;
      remaining  <= '0;
      ret_cnt    <= '0;
      occ        <= 2'd0;
      buf0       <= '0;
      buf1       <= '0;
    end else begin
      done_q   <= 1'b0;
      inflight <= rd;
      if (rd && want_body) issued_cnt <= issued_cnt + LEN_W'(1);
      if (inflight)        ret_cnt    <= ret_cnt + LEN_W'(1);

      // buf0 is always the head; a full buffer never coincides with a word in flight.
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= new_beat;
          else             buf1 <= new_beat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= new_beat;
          end else begin
            buf0 <= new_beat;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (bus.fifo_sel_code[7] && (32'(bus.fifo_sel_code[6:0]) < PORT_NUM)) begin
            lock_port  <= bus.fifo_sel_code[6:0];
            busy_q     <= 1'b1;
            hdr_issued <= 1'b0;
            issued_cnt <= '0;
            ret_cnt    <= '0;
            remaining  <= '0;
            state      <= HDR;
          end
        end
        HDR: begin
          if (rd && want_hdr) hdr_issued <= 1'b1;
          if (hdr_ret) begin
            remaining <= rem_now;
            state     <= ((rem_now == '0) || last_issue) ? DRAIN : BODY;
          end
        end
        BODY: begin
          if (last_issue) state <= DRAIN;
        end
        DRAIN: begin
          if (!inflight && (occ == 2'd0)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
